// File: rtl/mem_sys_pkg.sv
// Shared types for the cached memory subsystem: address fields, FSM states,
// word/line storage types.
package mem_sys_pkg;

  localparam int TAG_W          = 5;
  localparam int INDEX_W        = 8;
  localparam int WOFF_W         = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int MEM_LAT        = 2;
  localparam int DATA_W         = 16;
  localparam int WAYS           = 2;
  localparam int SETS           = 1 << INDEX_W;

  typedef logic [DATA_W-1:0]         word_t;
  typedef logic [TAG_W-1:0]          tag_t;
  typedef logic [INDEX_W-1:0]        index_t;
  typedef logic [WOFF_W-1:0]         woff_t;
  typedef logic [INDEX_W+WOFF_W-1:0] dptr_t;

  // Word address = byte address [15:1]: tag [15:11], index [10:3], word [2:1].
  typedef struct packed {
    tag_t   tag;
    index_t index;
    woff_t  woff;
  } waddr_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, WAIT, COMPLETE
  } state_t;

endpackage

// File: rtl/mem_system_cached_if.sv
// Processor-side request/response bundle of the cached memory subsystem.
interface mem_system_cached_if;
  import mem_sys_pkg::*;

  logic [15:0] Addr;
  word_t       DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  word_t       DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit
  );

endinterface

// File: rtl/four_bank_mem.sv
// 32K x 16 main memory split into 4 word-interleaved banks; writes land at the
// edge, reads come back MEM_LAT cycles after issue tagged with their bank.
module four_bank_mem
  import mem_sys_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_wr_en,
  input  logic   i_rd_en,
  input  waddr_t i_addr,
  input  word_t  i_wdata,
  output logic   o_rvalid,
  output woff_t  o_rword,
  output word_t  o_rdata
);

  localparam int ROWS = 1 << (TAG_W + INDEX_W);

  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] w_bank_q;
  logic                                  r_rd_v0;
  woff_t                                 r_bank0;
  word_t                                 r_pd [MEM_LAT-1];
  woff_t                                 r_pb [MEM_LAT-1];
  logic [MEM_LAT-2:0]                    r_pv;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
      word_t r_mem [ROWS];
      word_t r_q;
      logic  w_sel;

      assign w_sel       = (i_addr.woff == woff_t'(gi));
      assign w_bank_q[gi] = r_q;

      always_ff @(posedge clk) begin
        if (i_wr_en && w_sel) r_mem[{i_addr.tag, i_addr.index}] <= i_wdata;
        if (i_rd_en && w_sel) r_q <= r_mem[{i_addr.tag, i_addr.index}];
      end
    end
  endgenerate

  // First latency cycle is the bank read itself; the rest is a delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v0 <= 1'b0;
      r_bank0 <= '0;
      r_pv    <= '0;
      for (int i = 0; i < MEM_LAT-1; i++) begin
        r_pd[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_rd_v0 <= i_rd_en;
      if (i_rd_en) r_bank0 <= i_addr.woff;
      r_pv[0] <= r_rd_v0;
      r_pd[0] <= w_bank_q[r_bank0];
      r_pb[0] <= r_bank0;
      for (int i = 1; i < MEM_LAT-1; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  assign o_rvalid = r_pv[MEM_LAT-2];
  assign o_rword  = r_pb[MEM_LAT-2];
  assign o_rdata  = r_pd[MEM_LAT-2];

endmodule

// File: rtl/mem_system_cached.sv
// 2-way set-associative write-back/write-allocate cache over four_bank_mem,
// one request at a time with a Done/Stall handshake.
module mem_system_cached
  import mem_sys_pkg::*;
(
  input logic                clk,
  input logic                rst,
  mem_system_cached_if.slave bus
);

  localparam int DEPTH = SETS * WORDS_PER_LINE;

  state_t          r_state, w_state_next;
  logic [SETS-1:0] r_valid [WAYS];
  logic [SETS-1:0] r_dirty [WAYS];
  logic [SETS-1:0] r_lru;
  tag_t            r_tags [WAYS][SETS];
  word_t           r_data [WAYS][DEPTH];

  waddr_t          r_req_q;
  logic            r_wr_q;
  word_t           r_wdata_q;
  logic            r_way_q;
  tag_t            r_vtag_q;
  logic [3:0]      r_wait_cnt;
  logic            r_done, r_hit;
  word_t           r_dout;

  waddr_t          w_req_addr;
  dptr_t           w_ptr, w_ptr_q;
  logic            w_req, w_accept, w_hit_acc, w_miss_acc;
  logic [WAYS-1:0] w_way_hit;
  logic            w_hit, w_hit_way, w_victim, w_victim_dirty;
  logic            w_mem_wr, w_mem_rd, w_mem_rvalid, w_fill;
  waddr_t          w_mem_addr;
  word_t           w_mem_wdata, w_mem_rdata;
  woff_t           w_mem_rword, w_step;
  logic            w_unused;

  assign w_req_addr = waddr_t'(bus.Addr[15:1]);
  assign w_ptr      = {w_req_addr.index, w_req_addr.woff};
  assign w_ptr_q    = {r_req_q.index, r_req_q.woff};
  assign w_req      = bus.Rd | bus.Wr;
  assign w_unused   = bus.createdump ^ bus.Addr[0];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_way_hit[gi] = r_valid[gi][w_req_addr.index] &&
                             (r_tags[gi][w_req_addr.index] == w_req_addr.tag);
    end
  endgenerate

  assign w_hit      = |w_way_hit;
  assign w_hit_way  = w_way_hit[1];
  assign w_accept   = (r_state == IDLE) && w_req;
  assign w_hit_acc  = w_accept && w_hit;
  assign w_miss_acc = w_accept && !w_hit;

  // Fill empty ways first (way0 before way1); only then fall back to LRU.
  always_comb begin
    w_victim = r_lru[w_req_addr.index];
    if (!r_valid[0][w_req_addr.index])      w_victim = 1'b0;
    else if (!r_valid[1][w_req_addr.index]) w_victim = 1'b1;
    w_victim_dirty = r_valid[w_victim][w_req_addr.index] &&
                     r_dirty[w_victim][w_req_addr.index];
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_wr     = 1'b0;
    w_mem_rd     = 1'b0;
    w_step       = '0;
    case (r_state)
      IDLE:     if (w_miss_acc) w_state_next = w_victim_dirty ? WB0 : RD0;
      WB0:      begin w_state_next = WB1;  w_mem_wr = 1'b1; w_step = 2'd0; end
      WB1:      begin w_state_next = WB2;  w_mem_wr = 1'b1; w_step = 2'd1; end
      WB2:      begin w_state_next = WB3;  w_mem_wr = 1'b1; w_step = 2'd2; end
      WB3:      begin w_state_next = RD0;  w_mem_wr = 1'b1; w_step = 2'd3; end
      RD0:      begin w_state_next = RD1;  w_mem_rd = 1'b1; w_step = 2'd0; end
      RD1:      begin w_state_next = RD2;  w_mem_rd = 1'b1; w_step = 2'd1; end
      RD2:      begin w_state_next = RD3;  w_mem_rd = 1'b1; w_step = 2'd2; end
      RD3:      begin w_state_next = WAIT; w_mem_rd = 1'b1; w_step = 2'd3; end
      WAIT:     if (r_wait_cnt == 4'(MEM_LAT-1)) w_state_next = COMPLETE;
      COMPLETE: w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
    w_mem_addr  = w_mem_wr ? waddr_t'({r_vtag_q, r_req_q.index, w_step})
                           : waddr_t'({r_req_q.tag, r_req_q.index, w_step});
    w_mem_wdata = r_data[r_way_q][{r_req_q.index, w_step}];
  end

  four_bank_mem u_mem (
    .clk      (clk),
    .rst_n    (rst),
    .i_wr_en  (w_mem_wr),
    .i_rd_en  (w_mem_rd),
    .i_addr   (w_mem_addr),
    .i_wdata  (w_mem_wdata),
    .o_rvalid (w_mem_rvalid),
    .o_rword  (w_mem_rword),
    .o_rdata  (w_mem_rdata)
  );

  assign w_fill = w_mem_rvalid && (r_state inside {RD0, RD1, RD2, RD3, WAIT});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      for (int i = 0; i < WAYS; i++) begin
        r_valid[i] <= '0;
        r_dirty[i] <= '0;
      end
      r_lru      <= '0;
      r_req_q    <= '0;
      r_wr_q     <= 1'b0;
      r_wdata_q  <= '0;
      r_way_q    <= 1'b0;
      r_vtag_q   <= '0;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
      if (w_hit_acc) begin
        r_done <= 1'b1;
        r_hit  <= 1'b1;
        r_lru[w_req_addr.index] <= ~w_hit_way;
        if (bus.Wr) r_dirty[w_hit_way][w_req_addr.index] <= 1'b1;
        else        r_dout <= r_data[w_hit_way][w_ptr];
      end
      if (w_miss_acc) begin
        r_req_q   <= w_req_addr;
        r_wr_q    <= bus.Wr;
        r_wdata_q <= bus.DataIn;
        r_way_q   <= w_victim;
        r_vtag_q  <= r_tags[w_victim][w_req_addr.index];
      end
      // Line is fully installed by now; finish the original access.
      if (r_state == COMPLETE) begin
        r_done <= 1'b1;
        r_valid[r_way_q][r_req_q.index] <= 1'b1;
        r_dirty[r_way_q][r_req_q.index] <= r_wr_q;
        r_lru[r_req_q.index]            <= ~r_way_q;
        if (!r_wr_q) r_dout <= r_data[r_way_q][w_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hit_acc && bus.Wr) r_data[w_hit_way][w_ptr] <= bus.DataIn;
    if (w_fill) r_data[r_way_q][{r_req_q.index, w_mem_rword}] <= w_mem_rdata;
    if (r_state == COMPLETE) begin
      r_tags[r_way_q][r_req_q.index] <= r_req_q.tag;
      if (r_wr_q) r_data[r_way_q][w_ptr_q] <= r_wdata_q;
    end
  end

  assign bus.DataOut  = r_dout;
  assign bus.Done     = r_done;
  assign bus.Stall    = (r_state != IDLE);
  assign bus.CacheHit = r_hit;

endmodule

// File: tb/tb_mem_system_cached.sv
// Directed + randomized bench for mem_system_cached against a flat word-array
// model with policy-independent hit expectations.
module tb_mem_system_cached;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_system_cached_if bus ();

  mem_system_cached dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_pulses = 0;
  int          n_req = 0;
  logic [15:0] model [32768];
  bit          touched [256];
  bit          phase2 = 1'b0;
  bit          last_v = 1'b0;
  logic [12:0] last_line = '0;

  always @(negedge clk) if (bus.Done === 1'b1) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller must be at a negedge. exp_hit/exp_lat < 0 mean "not checked".
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int exp_hit, input int exp_lat);
    int          lat;
    bit          got;
    bit          must_hit;
    logic [15:0] dout;
    logic        hit;
    logic [14:0] wa;
    wa       = a[15:1];
    must_hit = (last_v && last_line == a[15:3]) || (phase2 && touched[a[10:3]]);
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
    got = 1'b0; lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.Done === 1'b1) got = 1'b1;
    end
    dout = bus.DataOut;
    hit  = bus.CacheHit;
    bus.Rd = 1'b0; bus.Wr = 1'b0;
    n_req++;
    $display("REQ %0d rd=%0b wr=%0b addr=%h din=%h lat=%0d hit=%0b dout=%h",
             n_req, rd, wr, a, d, lat, hit, dout);
    chk("done_within_bound", 32'(got), 32'd1);
    if (!got) return;
    if (!wr) chk("read_data", 32'(dout), 32'(model[wa]));
    else     model[wa] = d;
    chk("stall_low_at_done", 32'(bus.Stall), 32'd0);
    if (hit) chk("hit_latency_le2", 32'(lat <= 2), 32'd1);
    else     chk("miss_latency_3_20", 32'(lat >= 3 && lat <= 20), 32'd1);
    if (must_hit)     chk("expected_hit", 32'(hit), 32'd1);
    if (exp_hit >= 0) chk("directed_hit", 32'(hit), 32'(exp_hit));
    if (exp_lat >= 0) chk("directed_latency", 32'(lat), 32'(exp_lat));
    last_v    = 1'b1;
    last_line = a[15:3];
    if (phase2) touched[a[10:3]] = 1'b1;
  endtask

  initial begin
    int          op;
    int          dp;
    logic [15:0] ra;
    for (int i = 0; i < 32768; i++) model[i] = '0;
    for (int i = 0; i < 256; i++) touched[i] = 1'b0;
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0; bus.createdump = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(bus.Done), 32'd0);
    chk("reset_stall", 32'(bus.Stall), 32'd0);
    chk("reset_cachehit", 32'(bus.CacheHit), 32'd0);
    chk("reset_dataout", 32'(bus.DataOut), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss then hit
    access(1'b1, 1'b0, 16'h0000, 16'h0000, 0, -1);
    access(1'b1, 1'b0, 16'h0000, 16'h0000, 1, 1);
    // Write-allocate then read hit
    access(1'b0, 1'b1, 16'h6010, 16'hBEEF, 0, -1);
    access(1'b1, 1'b0, 16'h6010, 16'h0000, 1, 1);
    // Both ways of set 1
    access(1'b0, 1'b1, 16'h0808, 16'h1234, 0, -1);
    access(1'b0, 1'b1, 16'h1008, 16'h5678, 0, -1);
    access(1'b1, 1'b0, 16'h0808, 16'h0000, 1, 1);
    access(1'b1, 1'b0, 16'h1008, 16'h0000, 1, 1);
    // Dirty evictions and refetch of the written-back data
    access(1'b1, 1'b0, 16'h1808, 16'h0000, 0, -1);
    access(1'b1, 1'b0, 16'h0808, 16'h0000, 0, -1);
    access(1'b1, 1'b0, 16'h1008, 16'h0000, 0, -1);

    // No request: nothing happens and DataOut holds the last read value
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_done", 32'(bus.Done), 32'd0);
      chk("idle_stall", 32'(bus.Stall), 32'd0);
      chk("idle_dataout_hold", 32'(bus.DataOut), 32'h5678);
    end

    // Make both ways dirty (same values as memory), then reset during write-back
    access(1'b0, 1'b1, 16'h0808, 16'h1234, -1, -1);
    access(1'b0, 1'b1, 16'h1008, 16'h5678, -1, -1);
    bus.Rd = 1'b1; bus.Addr = 16'h1808;
    @(negedge clk);
    chk("wb_stall_high", 32'(bus.Stall), 32'd1);
    dp  = done_pulses;
    rst = 1'b0;
    #1;
    chk("midmiss_reset_stall", 32'(bus.Stall), 32'd0);
    chk("midmiss_reset_done", 32'(bus.Done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midmiss_no_done", 32'(done_pulses), 32'(dp));
    bus.Rd = 1'b0;
    rst    = 1'b1;
    last_v = 1'b0;
    access(1'b1, 1'b0, 16'h0808, 16'h0000, 0, -1);

    // Random, full address range (Addr[0] and Rd=Wr=1 included)
    for (int i = 0; i < 1000; i++) begin
      op = $urandom_range(0, 3);
      access(op != 2, op >= 2, 16'($urandom), 16'($urandom), -1, -1);
    end

    // Random, constant tag: every set touched here must hit afterwards
    phase2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = $urandom_range(0, 3);
      ra = (16'($urandom) & 16'h07FE) | 16'h6000;
      access(op != 2, op >= 2, ra, 16'($urandom), -1, -1);
    end

    repeat (3) @(negedge clk);
    chk("one_done_per_request", 32'(done_pulses), 32'(n_req));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
